// File: rtl/pc_target_lut_rw.sv
// Runtime-programmable branch-target lookup table for the fetch stage.
// Latency: one cycle from i_lk_req to o_target_valid; throughput one lookup per cycle.
// Backpressure: none; each accepted request produces exactly one result pulse.
//
// Optional feature macro: PC_LUT_PERF_EN (adds o_hit_cnt / o_miss_cnt).
//
// Ports:
//   i_clk, i_reset     clock (rising edge), asynchronous active-high reset
//   i_lk_req           lookup request; i_lk_addr selects the entry, i_pc is sampled with it
//   o_target           resolved branch target (absolute, pc+offset, or pc+1 on miss)
//   o_target_valid     one-cycle strobe per accepted request
//   o_miss             addressed entry was invalid, o_target = pc+1
//   i_wr_en            table write strobe: {i_wr_data, i_wr_rel} into entry i_wr_addr
//   i_wr_rel           1 = entry holds a signed pc-relative offset, 0 = absolute target
//   i_clr              synchronous invalidate of every entry (beats a same-cycle write)
//   o_hit_cnt/o_miss_cnt  saturating 16-bit result counters (PC_LUT_PERF_EN only)

module pc_target_lut_rw #(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_lk_req,
    input  logic [A-1:0] i_lk_addr,
    input  logic [D-1:0] i_pc,
    output logic [D-1:0] o_target,
    output logic         o_target_valid,
    output logic         o_miss,
    input  logic         i_wr_en,
    input  logic [A-1:0] i_wr_addr,
    input  logic [D-1:0] i_wr_data,
    input  logic         i_wr_rel,
    input  logic         i_clr
`ifdef PC_LUT_PERF_EN
    ,
    output logic [15:0]  o_hit_cnt,
    output logic [15:0]  o_miss_cnt
`endif
);

    localparam int N = 1 << A;

    // Entry payload (value + mode) is deliberately not reset: it is only ever
    // consumed when the matching valid bit is set, and valid bits are reset.
    logic [D-1:0] r_val [N];
    logic [N-1:0] r_rel;
    logic [N-1:0] r_vld;

    logic [D-1:0] r_target;
    logic         r_target_valid;
    logic         r_miss;

    logic         w_wr_go;
    logic         w_byp;
    logic [D-1:0] w_ent_val;
    logic         w_ent_rel;
    logic         w_ent_vld;
    logic [D-1:0] w_res_tgt;
    logic         w_res_miss;

    // A write in the same cycle as clr is dropped.
    assign w_wr_go = i_wr_en && !i_clr;

    //--------------------------------------------------------------------
    // Table storage
    //--------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_wr_go) begin
            r_val[i_wr_addr] <= i_wr_data;
            r_rel[i_wr_addr] <= i_wr_rel;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld <= '0;
        end else if (i_clr) begin
            r_vld <= '0;
        end else if (i_wr_en) begin
            r_vld[i_wr_addr] <= 1'b1;
        end
    end

    //--------------------------------------------------------------------
    // Lookup resolution
    //--------------------------------------------------------------------
    // Write-first: a write landing on the looked-up index on this edge is
    // forwarded straight into the lookup. A same-cycle clr forces a miss.
    assign w_byp     = w_wr_go && (i_wr_addr == i_lk_addr);
    assign w_ent_val = w_byp ? i_wr_data : r_val[i_lk_addr];
    assign w_ent_rel = w_byp ? i_wr_rel  : r_rel[i_lk_addr];
    assign w_ent_vld = !i_clr && (w_byp || r_vld[i_lk_addr]);

    // D-bit addition wraps silently; an offset with its MSB set acts as a
    // negative two's-complement displacement.
    always_comb begin
        w_res_tgt  = i_pc + D'(1);
        w_res_miss = 1'b1;
        if (w_ent_vld) begin
            w_res_miss = 1'b0;
            if (w_ent_rel) begin
                w_res_tgt = i_pc + w_ent_val;
            end else begin
                w_res_tgt = w_ent_val;
            end
        end
    end

    //--------------------------------------------------------------------
    // Registered result; target/miss hold between requests
    //--------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_target       <= '0;
            r_target_valid <= 1'b0;
            r_miss         <= 1'b0;
        end else begin
            r_target_valid <= i_lk_req;
            if (i_lk_req) begin
                r_target <= w_res_tgt;
                r_miss   <= w_res_miss;
            end
        end
    end

    assign o_target       = r_target;
    assign o_target_valid = r_target_valid;
    assign o_miss         = r_miss;

`ifdef PC_LUT_PERF_EN
    //--------------------------------------------------------------------
    // Saturating hit / miss counters, counted off the visible result strobe
    //--------------------------------------------------------------------
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (i_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_target_valid) begin
            if (r_miss) begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end else begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

endmodule
